cdc_wr_arbiter: RTL

//  Shares port 1 (clk1 side: wr1/data1/wait1) of the byte clock-domain-crossing channel between
//  N_REQ clk1-domain requesters (CPU store path, TWI controller, debug).

---
 rtl/cdc_wr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/cdc_wr_arbiter.sv
// Round-robin arbiter sharing the clk1 write port of the byte CDC channel; one byte in flight, grant-to-done >= 3 cycles.
// Backpressure: no grant while cdc_wait1 is high; BUSY holds until wait1 clears (CDC_ARB_TIMEOUT_EN adds an abort after TO_CYC).
module cdc_wr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DW     = 8,
  parameter int TO_CYC = 1023
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic                busy,
  output logic                cdc_wr1,
  output logic [DW-1:0]       cdc_data1,
  input  logic                cdc_wait1
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, WRITE, BUSY, DONE} state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  rr_ptr, gnt_idx, sel_idx;
  logic           sel_vld;
  logic           to_exp;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int p;
    p       = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      p = (int'(rr_ptr) + k) % N_REQ;
      if (req[p[IW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = p[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel_vld && !cdc_wait1) state_nx = WRITE;
      WRITE:   state_nx = BUSY;
      BUSY:    if (!cdc_wait1 || to_exp) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      cdc_data1 <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == WRITE) begin
        gnt_idx   <= sel_idx;
        cdc_data1 <= req_data[int'(sel_idx)*DW +: DW];
      end
      if (state == DONE) begin
        rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
    end
  end

  assign cdc_wr1 = (state == WRITE);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] to_cnt;
  logic          to_err;

  // Counter is zero in the first BUSY cycle, so the abort lands after TO_CYC BUSY cycles.
  assign to_exp = (state == BUSY) && (to_cnt == CW'(TO_CYC - 1));

  always_ff @(posedge clk1) begin
    if (!rst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (state == WRITE) begin
        to_cnt <= '0;
        to_err <= 1'b0;
      end else if (state == BUSY) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (to_exp && cdc_wait1) to_err <= 1'b1;
    end
  end

  assign err = (state == DONE) && to_err;
`else
  logic unused_cfg;

  assign unused_cfg = (TO_CYC > 0);
  assign to_exp     = 1'b0;
  assign err        = 1'b0;
`endif

endmodule
